// File: rtl/alu_issue.sv
// alu_issue: command FIFO that feeds an alu from registers (alu_*), captures its result for a res_* handshake and keeps an accumulator (acc_q) that commands can chain from. Commands enter on cmd_*; fifo_count reports FIFO occupancy.
module alu_issue #(
  parameter int N = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [N-1:0]                 cmd_in0,
  input  logic [N-1:0]                 cmd_in1,
  input  logic [3:0]                   cmd_op,
  input  logic                         cmd_acc,
  output logic [N-1:0]                 alu_in0,
  output logic [N-1:0]                 alu_in1,
  output logic [3:0]                   alu_op,
  input  logic [N-1:0]                 alu_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [N-1:0]                 res_data,
  output logic [3:0]                   res_op,
  output logic [N-1:0]                 acc_q,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2*N+5;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [EW-1:0] head;
  logic push, pop;
  assign cmd_ready = !reset && fifo_count != CW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = fifo_count != '0 && (state == IDLE || (state == HOLD && res_ready));
  assign head = mem[rptr];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {cmd_in0, cmd_in1, cmd_op, cmd_acc};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      alu_in0 <= '0;
      alu_in1 <= '0;
      alu_op <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_op <= '0;
      acc_q <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (pop) begin
        alu_in0 <= head[0] ? acc_q : head[EW-1 -: N];
        alu_in1 <= head[N+4 -: N];
        alu_op <= head[4:1];
      end
      unique case (state)
        IDLE: state <= pop ? ISSUE : IDLE;
        ISSUE: begin
          res_data <= alu_out;
          res_op <= alu_op;
          acc_q <= alu_out;
          res_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state <= pop ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of alu_issue against an adder alu stub
module tb_alu_issue;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_acc = 0, res_valid, res_ready = 1;
  logic [7:0] cmd_in0 = 0, cmd_in1 = 0, alu_in0, alu_in1, alu_out, res_data, acc_q;
  logic [3:0] cmd_op = 0, alu_op, res_op;
  logic [2:0] fifo_count;
  int passed = 0, failed = 0, total = 0;
  alu_issue #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in0(cmd_in0), .cmd_in1(cmd_in1), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .acc_q(acc_q), .fifo_count(fifo_count)
  );
  assign alu_out = alu_in0 + alu_in1;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic acc);
    cmd_in0 = a;
    cmd_in1 = b;
    cmd_op = op;
    cmd_acc = acc;
    cmd_valid = 1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("push_ready", 64'(cmd_ready), 64'h1);
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic get_result(input logic [7:0] d, input logic [3:0] op);
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    chk("res_valid", 64'(res_valid), 64'h1);
    chk("res_data", 64'(res_data), 64'(d));
    chk("res_op", 64'(res_op), 64'(op));
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 64'(cmd_ready), 64'h0);
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'h1);
    chk("reset_outs", 64'({res_valid, res_data, res_op, acc_q, alu_in0, alu_in1, alu_op, fifo_count}), 64'h0);
    push(8'h94, 8'h18, 4'h0, 1'b0);
    chk("lat_k_valid", 64'(res_valid), 64'h0);
    chk("lat_k_count", 64'(fifo_count), 64'h1);
    @(negedge clk);
    chk("lat_k1_valid", 64'(res_valid), 64'h0);
    chk("lat_k1_issue", 64'({alu_in0, alu_in1, alu_op}), 64'h94180);
    chk("lat_k1_count", 64'(fifo_count), 64'h0);
    @(negedge clk);
    chk("lat_k2_valid", 64'(res_valid), 64'h1);
    chk("lat_k2_data", 64'(res_data), 64'hac);
    chk("lat_k2_op", 64'(res_op), 64'h0);
    chk("lat_k2_acc", 64'(acc_q), 64'hac);
    @(negedge clk);
    chk("single_done", 64'(res_valid), 64'h0);
    push(8'h80, 8'h01, 4'h1, 1'b0);
    push(8'hff, 8'h01, 4'h1, 1'b1);
    get_result(8'h81, 4'h1);
    get_result(8'h82, 4'h1);
    chk("chain_acc", 64'(acc_q), 64'h82);
    chk("chain_in0", 64'(alu_in0), 64'h81);
    push(8'hc3, 8'hb4, 4'h3, 1'b0);
    get_result(8'h77, 4'h3);
    res_ready = 0;
    for (int i = 1; i <= 5; i++) push(8'(i), 8'h00, 4'h2, 1'b0);
    chk("full_ready", 64'(cmd_ready), 64'h0);
    chk("full_count", 64'(fifo_count), 64'h4);
    chk("full_hold", 64'(res_valid), 64'h1);
    cmd_in0 = 8'h06;
    cmd_in1 = 8'h00;
    cmd_op = 4'h2;
    cmd_acc = 0;
    cmd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", 64'(res_data), 64'h1);
      chk("stall_ready", 64'(cmd_ready), 64'h0);
      chk("stall_count", 64'(fifo_count), 64'h4);
    end
    res_ready = 1;
    @(negedge clk);
    chk("full_pop_count", 64'(fifo_count), 64'h3);
    chk("full_pop_valid", 64'(res_valid), 64'h0);
    chk("full_pop_ready", 64'(cmd_ready), 64'h1);
    @(negedge clk);
    chk("refill_count", 64'(fifo_count), 64'h4);
    cmd_valid = 0;
    for (int i = 2; i <= 6; i++) get_result(8'(i), 4'h2);
    chk("drain_count", 64'(fifo_count), 64'h0);
    res_ready = 0;
    push(8'h10, 8'h00, 4'h5, 1'b0);
    push(8'h20, 8'h00, 4'h5, 1'b0);
    @(negedge clk);
    chk("pp_hold_data", 64'(res_data), 64'h10);
    chk("pp_hold_count", 64'(fifo_count), 64'h1);
    cmd_in0 = 8'h30;
    cmd_valid = 1;
    res_ready = 1;
    @(negedge clk);
    cmd_valid = 0;
    chk("pp_count", 64'(fifo_count), 64'h1);
    chk("pp_valid", 64'(res_valid), 64'h0);
    get_result(8'h20, 4'h5);
    get_result(8'h30, 4'h5);
    res_ready = 0;
    for (int i = 1; i <= 5; i++) push(8'(8'h40 + i), 8'h00, 4'h6, 1'b0);
    res_ready = 1;
    @(negedge clk);
    chk("rst_pre_count", 64'(fifo_count), 64'h3);
    chk("rst_pre_in0", 64'(alu_in0), 64'h42);
    reset = 1;
    cmd_in0 = 8'h99;
    cmd_valid = 1;
    @(negedge clk);
    chk("rst_outs", 64'({res_valid, res_data, res_op, acc_q, alu_in0, alu_in1, alu_op, fifo_count}), 64'h0);
    chk("rst_ready", 64'(cmd_ready), 64'h0);
    reset = 0;
    cmd_valid = 0;
    @(negedge clk);
    chk("rst_rel_ready", 64'(cmd_ready), 64'h1);
    chk("rst_rel_count", 64'(fifo_count), 64'h0);
    chk("rst_rel_valid", 64'(res_valid), 64'h0);
    push(8'h05, 8'h00, 4'h4, 1'b0);
    get_result(8'h05, 4'h4);
    repeat (6) @(negedge clk);
    chk("no_stale_valid", 64'(res_valid), 64'h0);
    chk("no_stale_count", 64'(fifo_count), 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Command-staging stage directly upstream of the `alu` datapath block. Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, and drives one command at a time onto the ALU's `in0`/`in1`/`op` inputs from registers. It captures the ALU's combinational `out` into a result register, presents it downstream over a valid/ready handshake, and keeps the last result as an accumulator that later commands can chain from.

## Interface
- `N`, 8: operand/result width. Must match the attached `alu` instance.
- `DEPTH`, 4: command FIFO entries. Power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_in0` in N: operand A.
- `cmd_in1` in N: operand B.
- `cmd_op` in 4: ALU opcode, passed through unmodified.
- `cmd_acc` in 1: when 1, operand A is replaced by `acc_q` at issue time.
- `alu_in0` out N: registered, connects to `alu.in0`.
- `alu_in1` out N: registered, connects to `alu.in1`.
- `alu_op` out 4: registered, connects to `alu.op`.
- `alu_out` in N: connects to `alu.out`. Combinational from `alu_*`.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out N: captured ALU result.
- `res_op` out 4: opcode that produced `res_data`.
- `acc_q` out N: last captured result.
- `fifo_count` out $clog2(DEPTH+1): FIFO occupancy.

## Operation
- FIFO write occurs when `cmd_valid && cmd_ready`. Stores {in0, in1, op, acc}. Order is strict FIFO. Pointers wrap modulo DEPTH.
- Pop and issue: the head entry is loaded into `alu_in0`/`alu_in1`/`alu_op`. If `acc` = 1, `alu_in0` is loaded with `acc_q` (its value after any capture on that same edge), not `cmd_in0`.
- The state machine has three states: IDLE, ISSUE and HOLD.
- **IDLE**:
  - If the FIFO is non-empty: pop and issue, then go to ISSUE.
  - Otherwise: stay in IDLE.
- **ISSUE**: lasts exactly one cycle. At the end of the cycle, capture `res_data`←`alu_out`, `res_op`←`alu_op`, `acc_q`←`alu_out`, set `res_valid`←1, then go to HOLD.
- **HOLD**: `res_valid` = 1, and `res_data`/`res_op` are held stable.
  - If `res_ready` = 1 and the FIFO is non-empty: pop and issue (this sees the updated `acc_q`), clear `res_valid`, then go to ISSUE.
  - If `res_ready` = 1 and the FIFO is empty: clear `res_valid`, then go to IDLE.
  - If `res_ready` = 0: stay in HOLD.
- `alu_*` outputs keep their last issued values while in IDLE and HOLD.
- Arithmetic: the block does no arithmetic. `alu_out` is taken as N bits exactly as produced (wrap is the ALU's behaviour).
- Full FIFO: `cmd_ready` = 0. A push is refused even if a pop happens on the same edge; there is no push-through when full.
- Empty FIFO: there is no bypass. A command written on edge k is popped no earlier than edge k+1.
- Simultaneous push and pop when neither full nor empty: both take effect, and `fifo_count` is unchanged.
- Reset, applied at any time including mid-operation:
  - FIFO is emptied; pending commands and any unaccepted result are discarded.
  - State returns to IDLE.
  - `cmd_ready` = 1 from the first cycle after reset. While `reset` is asserted, `cmd_ready` = 0 and no writes occur.
  - All other outputs reset to 0: `res_valid`, `res_data`, `res_op`, `acc_q`, `alu_in0`, `alu_in1`, `alu_op`, `fifo_count`.

## Timing
Latency from an accepting edge k (command accepted into an empty FIFO, block in IDLE):
- Edge k+1: pop. `alu_*` are valid and the state is ISSUE during cycle k+1→k+2.
- Edge k+2: capture. `res_valid` = 1 from k+2.
- Best-case throughput is one result per 2 cycles, with `res_ready` held at 1.
- `res_valid` never drops without a handshake, except on reset.
- `cmd_ready` depends only on registered state, with no combinational path from `res_ready`.

## Test plan
All tests use N=8 and DEPTH=4. The bench ALU stub computes `alu_out` = (`alu_in0` + `alu_in1`) mod 256.
- **Single command, latency:** one command {0x94, 0x18, op 0000, acc 0}, `res_ready` = 1 → `res_data` = 0xAC, `res_op` = 0000, `res_valid` rises exactly 2 edges after the accepting edge, `acc_q` = 0xAC.
- **Accumulator chaining:** {0x80, 0x01, op 0001, acc 0}, then {0xFF, 0x01, op 0001, acc 1} → results 0x81, then 0x82 (0xFF ignored), `acc_q` = 0x82.
- **Result wrap:** {0xC3, 0xB4, op 0011} → `res_data` = 0x77.
- **Backpressure and full FIFO:** hold `res_ready` = 0 and offer 6 commands with in0 = 1..6, in1 = 0:
  - After 5 accepts (1 held in HOLD, 4 in the FIFO), `cmd_ready` = 0 and `fifo_count` = 4.
  - Release `res_ready` → results arrive in order 1..6, and `res_data` is stable on every stalled cycle.
- **Simultaneous push/pop:** push on the same edge as a HOLD handshake pop → `fifo_count` is unchanged and order is preserved.
- **Reset mid-operation:** assert `reset` during ISSUE with 3 commands queued → the next cycle has all outputs 0 and `fifo_count` = 0. After reset releases, a new {0x05, 0x00 (in1), op 0100} yields 0x05 only, with no stale results.
